// File: rtl/vrf_pkg.sv
// Shared widths and types for the vector register file and its streaming port.
package vrf_pkg;

  localparam int DWIDTH_RFADD = 5;
  localparam int DWIDTH_VEC   = 32;

  typedef logic [DWIDTH_RFADD-1:0] vrf_addr_t;
  typedef logic [DWIDTH_VEC-1:0]   vec_t;

  // Read pair as carried on out_data: {rd2, rd1}.
  typedef struct packed {
    vec_t rd2;
    vec_t rd1;
  } vec_pair_t;

endpackage

// File: rtl/vrf_out_fifo.sv
// Synchronous FIFO buffering registered VRF read pairs towards the consumer.
// No fall-through: a push into an empty FIFO becomes visible on the next cycle.
module vrf_out_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic                       valid,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] buf_q [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count_q;
  logic             full;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign valid   = (count_q != '0);
  assign pop_ok  = pop & valid;
  assign push_ok = push & ~full;

  // NOTE: storage has no reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) buf_q[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_data = buf_q[rd_ptr];
  assign count     = count_q;

endmodule

// File: rtl/vrf_stream_port.sv
// Vector register file with a credit-controlled registered read stream and a
// valid-qualified write stream, fed by the vector address auto-incrementer.
module vrf_stream_port
  import vrf_pkg::*;
#(
  parameter int DWIDTH_RFADD = vrf_pkg::DWIDTH_RFADD,
  parameter int DWIDTH_VEC   = vrf_pkg::DWIDTH_VEC,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rd_req,
  input  logic [DWIDTH_RFADD-1:0]       vr_addr1,
  input  logic [DWIDTH_RFADD-1:0]       vr_addr2,
  input  logic                          wr_req,
  input  logic [DWIDTH_RFADD-1:0]       vw_addr,
  input  logic [DWIDTH_VEC-1:0]         in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          flush,
  output logic                          stall_rd,
  output logic                          stall_wr,
  output logic [2*DWIDTH_VEC-1:0]       out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] CREDIT_MAX = (CW+1)'(FIFO_DEPTH);

  logic [DWIDTH_VEC-1:0]   mem [2**DWIDTH_RFADD];
  logic [2*DWIDTH_VEC-1:0] rd_q;
  logic                    rd_inflight;
  logic                    rd_issue;
  logic                    wr_fire;
  logic                    pop;
  logic [CW:0]             credit_used;

  assign in_ready = wr_req;
  assign stall_wr = wr_req & ~in_valid;
  assign wr_fire  = wr_req & in_valid;

  // Slots already committed: queued entries plus the read whose data lands next edge.
  // Same-cycle pops are deliberately not credited, keeping out_ready off this path.
  assign credit_used = {1'b0, fifo_count} + {{CW{1'b0}}, rd_inflight};
  assign stall_rd    = rd_req & (credit_used >= CREDIT_MAX);
  assign rd_issue    = rd_req & ~stall_rd;
  assign pop         = out_valid & out_ready;

  // Both the write and the read sample the pre-edge array, so a same-address
  // read in the write cycle returns the old contents.
  always_ff @(posedge clk) begin
    if (wr_fire)  mem[vw_addr] <= in_data;
    if (rd_issue) rd_q <= {mem[vr_addr2], mem[vr_addr1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_inflight <= 1'b0;
    else if (flush) rd_inflight <= 1'b0;
    else            rd_inflight <= rd_issue;
  end

  vrf_out_fifo #(
    .WIDTH (2*DWIDTH_VEC),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (rd_inflight),
    .push_data (rd_q),
    .pop       (pop),
    .head_data (out_data),
    .valid     (out_valid),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_vrf_stream_port.sv
// Self-checking bench for vrf_stream_port: queue-based reference model compared
// every cycle, plus directed literal scenarios and a randomized soak.
module tb_vrf_stream_port;
  import vrf_pkg::*;

  localparam int FD = 4;

  logic        clk;
  logic        rst;
  logic        rd_req;
  logic [4:0]  vr_addr1;
  logic [4:0]  vr_addr2;
  logic        wr_req;
  logic [4:0]  vw_addr;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic        stall_rd;
  logic        stall_wr;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  fifo_count;

  vrf_stream_port #(.DWIDTH_RFADD(5), .DWIDTH_VEC(32), .FIFO_DEPTH(FD)) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_req     (rd_req),
    .vr_addr1   (vr_addr1),
    .vr_addr2   (vr_addr2),
    .wr_req     (wr_req),
    .vw_addr    (vw_addr),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .flush      (flush),
    .stall_rd   (stall_rd),
    .stall_wr   (stall_wr),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  // Reference model: array contents, queued read pairs, and the one read whose
  // data is captured but not yet queued.
  logic [31:0] mem_m [32];
  vec_pair_t   q_m [$];
  bit          infl_m;
  vec_pair_t   pend_m;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_m.delete();
    infl_m = 1'b0;
  endtask

  function automatic bit model_stall();
    return rd_req && ((q_m.size() + int'(infl_m)) >= FD);
  endfunction

  // Advances the model across one clock edge using the inputs held at that edge.
  task automatic model_update();
    bit        issue;
    bit        pop;
    vec_pair_t nd;
    if (rst) begin
      model_reset();
    end else begin
      issue = rd_req && !model_stall();
      pop   = (q_m.size() != 0) && out_ready;
      nd    = {mem_m[vr_addr2], mem_m[vr_addr1]};
      if (flush) begin
        model_reset();
      end else begin
        if (pop)    void'(q_m.pop_front());
        if (infl_m) q_m.push_back(pend_m);
        infl_m = issue;
        pend_m = nd;
      end
      if (wr_req && in_valid) mem_m[vw_addr] = in_data;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_update();
  endtask

  task automatic set_in(input logic rr, input int a1, input int a2, input logic wr,
                        input int wa, input logic [31:0] d, input logic iv,
                        input logic orr, input logic fl);
    rd_req    = rr;
    vr_addr1  = 5'(a1);
    vr_addr2  = 5'(a2);
    wr_req    = wr;
    vw_addr   = 5'(wa);
    in_data   = d;
    in_valid  = iv;
    out_ready = orr;
    flush     = fl;
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", 64'(out_valid), 64'(q_m.size() != 0));
      check("fifo_count", 64'(fifo_count), 64'(q_m.size()));
      if (q_m.size() != 0) check("out_data", out_data, q_m[0]);
      check("stall_rd", 64'(stall_rd), 64'(model_stall()));
      check("stall_wr", 64'(stall_wr), 64'(wr_req && !in_valid));
      check("in_ready", 64'(in_ready), 64'(wr_req));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int issues;
    int first_stall;
    int a;
    logic [3:0] iv_seq;

    rst = 1'b1;
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #2;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset fifo_count", 64'(fifo_count), 64'd0);
    check("reset stall_rd", 64'(stall_rd), 64'd0);
    rd_req = 1'b0;
    step();
    step();
    rst    = 1'b0;
    chk_en = 1'b1;

    // Write sweep over the whole array, data 0x100+addr.
    for (int i = 0; i < 32; i++) begin
      set_in(0, 0, 0, 1, i, 32'h100 + 32'(i), 1, 1, 0);
      step();
    end

    // Read sweep 0..7: first data two cycles after the first issue, no stalls.
    for (int i = 0; i < 10; i++) begin
      set_in(i < 8, i, i, 0, 0, 0, 0, 1, 0);
      #1;
      check("sweep stall_rd", 64'(stall_rd), 64'd0);
      check("sweep out_valid", 64'(out_valid), 64'(i >= 2));
      if (i >= 2) check("sweep out_data", out_data, {32'h100 + 32'(i-2), 32'h100 + 32'(i-2)});
      step();
    end

    // Back-pressure: consumer stalled, exactly FD reads get through.
    issues = 0;
    first_stall = -1;
    for (int i = 0; i < 8; i++) begin
      set_in(1, i, 7 - i, 0, 0, 0, 0, 0, 0);
      #1;
      if (!stall_rd) issues++;
      else if (first_stall < 0) first_stall = i;
      step();
    end
    check("bp issued", 64'(issues), 64'd4);
    check("bp first stall", 64'(first_stall), 64'd4);
    check("bp fifo_count", 64'(fifo_count), 64'd4);
    for (int i = 8; i < 12; i++) begin
      set_in(1, i, i, 0, 0, 0, 0, 1, 0);
      step();
    end
    repeat (8) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
      step();
    end

    // Write starvation: address held while in_valid is low.
    iv_seq = 4'b1001;
    a = 10;
    for (int i = 0; i < 4; i++) begin
      set_in(0, 0, 0, 1, a, 32'hC0DE_0000 + 32'(i), iv_seq[i], 1, 0);
      #1;
      check("starve stall_wr", 64'(stall_wr), 64'(!iv_seq[i]));
      step();
      if (iv_seq[i]) a++;
    end
    set_in(1, 10, 11, 0, 0, 0, 0, 1, 0);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step();
    #1;
    check("starve readback", out_data, {32'hC0DE_0003, 32'hC0DE_0000});
    step();

    // Read-first hazard on address 3.
    set_in(0, 0, 0, 1, 3, 32'h55, 1, 1, 0);
    step();
    set_in(1, 3, 3, 1, 3, 32'hAA, 1, 1, 0);
    step();
    set_in(1, 3, 3, 0, 0, 0, 0, 1, 0);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    #1;
    check("rf old data", 64'(out_data[31:0]), 64'h55);
    step();
    #1;
    check("rf new data", 64'(out_data[31:0]), 64'hAA);
    step();
    repeat (3) step();

    // Flush with three entries queued and one read in flight.
    for (int i = 0; i < 4; i++) begin
      set_in(1, i, i, 0, 0, 0, 0, 0, 0);
      step();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    check("pre-flush count", 64'(fifo_count), 64'd3);
    step();
    set_in(1, 5, 5, 0, 0, 0, 0, 1, 0);
    #1;
    check("flush out_valid", 64'(out_valid), 64'd0);
    check("flush fifo_count", 64'(fifo_count), 64'd0);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    #1;
    check("post-flush early", 64'(out_valid), 64'd0);
    step();
    #1;
    check("post-flush valid", 64'(out_valid), 64'd1);
    check("post-flush data", out_data, {32'h105, 32'h105});
    step();
    step();

    // Asynchronous reset between edges drops the queue immediately.
    for (int i = 0; i < 3; i++) begin
      set_in(1, i + 20, i + 21, 0, 0, 0, 0, 0, 0);
      step();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    #2;
    check("pre-reset count", 64'(fifo_count), 64'd3);
    rst = 1'b1;
    model_reset();
    #1;
    check("async out_valid", 64'(out_valid), 64'd0);
    check("async fifo_count", 64'(fifo_count), 64'd0);
    step();
    rst = 1'b0;
    step();

    // Randomized soak against the model.
    for (int i = 0; i < 3000; i++) begin
      set_in(1'($urandom_range(0, 1)), $urandom_range(0, 31), $urandom_range(0, 31),
             1'($urandom_range(0, 1)), $urandom_range(0, 31), $urandom,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 31) == 0));
      step();
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vrf_stream_port.md
Name: vrf_stream_port

Overview:
- Vector register file (VRF) plus streaming port logic. Sits directly downstream of the vector address auto-incrementer.
- Consumes the auto-incremented read addresses (vr_addr1/vr_addr2) and write address (vw_addr) each cycle, and returns stall_rd/stall_wr to it.
- Reads are buffered in a small output FIFO drained by the streamout/PE consumer through valid/ready. Writes come from a valid-qualified input stream (vle32 load data or PE results).

Parameters:
- DWIDTH_RFADD, 5, VRF address width; depth = 2**DWIDTH_RFADD entries.
- DWIDTH_VEC, 32, bits per VRF entry.
- FIFO_DEPTH, 4, output FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- rd_req  in  1  a read element is wanted this cycle (streamout/vse32/vmacc counting).
- vr_addr1  in  DWIDTH_RFADD  read address port 1.
- vr_addr2  in  DWIDTH_RFADD  read address port 2.
- wr_req  in  1  a write element is expected this cycle (vle32/vmacc counting).
- vw_addr  in  DWIDTH_RFADD  write address.
- in_data  in  DWIDTH_VEC  write data.
- in_valid  in  1  in_data valid.
- in_ready  out  1  = wr_req; the element is consumed when in_valid & in_ready.
- flush  in  1  synchronous clear of the FIFO and the in-flight read.
- stall_rd  out  1  read back-pressure to the address generator.
- stall_wr  out  1  write starvation to the address generator.
- out_data  out  2*DWIDTH_VEC  {rd2, rd1} FIFO head.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts the head.
- fifo_count  out  clog2(FIFO_DEPTH)+1  occupancy, for debug/verification.

Behaviour:
Reset (async assert; release sampled on clk):
- FIFO pointers, fifo_count and rd_inflight = 0.
- out_valid = 0.
- stall_rd = 0, stall_wr = 0 unless their inputs force otherwise (both are combinational).
- VRF storage is not reset.

Read path:
- rd_issue = rd_req & ~stall_rd.
- Array read is registered: data for the addresses presented at cycle N is pushed into the FIFO at the clock edge ending cycle N+1, so it is visible on out_data in cycle N+2.
- rd_inflight is a 1-bit register = rd_issue from the previous cycle.
- Credit rule: stall_rd = rd_req & (fifo_count + rd_inflight >= FIFO_DEPTH).
  - An issued read always has a slot; the FIFO never overflows.
  - Pops in the current cycle are not credited (conservative, no comb path from out_ready).
- Pop = out_valid & out_ready.
- Push and pop in the same cycle: fifo_count unchanged, data order preserved.
- Push into an empty FIFO: out_valid rises the cycle after the push; no fall-through.
- Pointers wrap modulo FIFO_DEPTH; fifo_count saturates logically at FIFO_DEPTH and can never exceed it.

Write path:
- wr_fire = wr_req & in_valid. The array is written at the clock edge with mem[vw_addr] <= in_data.
- stall_wr = wr_req & ~in_valid, so the address generator holds vw_addr.
- in_valid while wr_req = 0 is ignored; no write occurs.

Hazards:
- A read and a write to the same address in one cycle return the OLD data (read-first).
- vr_addr1 == vr_addr2 is legal; both halves of out_data carry the same data.

Flush:
- Next cycle: FIFO empty, rd_inflight = 0, any read issued in the flush cycle is discarded.
- Writes are unaffected.
- flush with rst asserted: rst dominates.

Reset mid-operation: any in-flight data is lost; the first post-reset rd_issue behaves as from an empty FIFO.

Decomposition:
- Shared package vrf_pkg: DWIDTH_RFADD/DWIDTH_VEC defaults, typedef vrf_addr_t, typedef vec_t, typedef vec_pair_t.
- One sub-module: vrf_out_fifo, a synchronous FIFO of width 2*DWIDTH_VEC and depth FIFO_DEPTH with push/pop/count/flush.
- The array and credit logic stay in the top module.

Test Plan:
- Write sweep: wr_req = 1, in_valid = 1, vw_addr 0..7 with in_data = 0x100+addr; then rd_req with vr_addr1 = vr_addr2 = 0..7 and out_ready = 1 -> out_data = {0x100+a, 0x100+a} in order, first valid 2 cycles after the first issue, stall_rd never asserted.
- Back-pressure: out_ready = 0, rd_req = 1 continuously -> exactly 4 reads issued. stall_rd rises once fifo_count + rd_inflight = 4 (cycle 4 after the first request). Raising out_ready resumes issue with no lost or duplicated element.
- Write starvation: wr_req = 1 with in_valid toggling 1,0,0,1 -> stall_wr = 0,1,1,0; only 2 writes occur, to the held addresses.
- Read-first: same cycle write mem[3] = 0xAA (old value 0x55) and read addr 3 -> out_data low half = 0x55; a read of addr 3 the next cycle returns 0xAA.
- Flush with 3 entries queued and a read in flight -> next cycle out_valid = 0, fifo_count = 0; the next read's data appears 2 cycles after it is issued.
- Async reset asserted mid-stream between clock edges -> out_valid and fifo_count drop to 0 immediately, before the next edge.
